mips_core: RTL and testbench
============================

Name: mips_core

Overview:
- Single-cycle 32-bit MIPS core: one instruction fetched, decoded, executed and retired per clock.
- Contains its own instruction ROM, register file, ALU and data RAM.
- Top-level simulation target: exports PC, current instruction and $v0 so a bench can detect `syscall` (0x0000000C) and report the result in $v0.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- DMEM_WORDS, 256, data memory depth in 32-bit words.
- IMEM_FILE, "program.hex", $readmemh image loaded into instruction memory at time 0.
- RESET_PC, 32'h0000_0000, PC value on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- PC  output  32  current program counter (byte address).
- inst_out  output  32  instruction at PC (combinational fetch).
- v0  output  32  live contents of register $2 ($v0).

Behaviour:
- Reset (async, rst=1):
  - PC := RESET_PC.
  - All 32 registers := 0.
  - Data memory not cleared.
  - Outputs during reset: PC=RESET_PC, v0=0, inst_out=imem[RESET_PC>>2].
- Fetch:
  - Internal net `inst` = imem[PC[log2(IMEM_WORDS)+1:2]], combinational; inst_out = inst.
  - The net name `inst` is fixed; benches probe it hierarchically.
  - Out-of-range addresses wrap on the index bits.
- Latency: every instruction completes in one cycle. Register/memory writes and the next-PC update occur on the same rising edge.
- Register file:
  - 32x32, two async read ports, one sync write port.
  - $0 reads 0 and ignores writes.
  - A read in the same cycle as a write to the same register returns the old value.
- Supported instructions (all others execute as NOP, PC+4):
  - R-type (op 0): add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- Arithmetic:
  - 32-bit wrap-around; no overflow traps (add behaves as addu).
  - slt is signed; sltu/sltiu are unsigned.
  - Immediates: addi/addiu/slti/sltiu/lw/sw/beq/bne sign-extend; andi/ori/xori zero-extend; lui places imm in [31:16].
  - Shifts use shamt [10:6].
- Memory:
  - lw/sw address = rs + sext(imm), word-aligned; low 2 bits ignored.
  - Data RAM: sync write, async read.
- Next PC:
  - Default PC+4.
  - beq/bne taken: PC+4+(sext(imm)<<2).
  - j/jal: {PC+4[31:28], target, 2'b00}; jal writes PC+4 to $31.
  - jr: rs.
- syscall (inst == 32'h0000000C):
  - Core halts: PC holds its value, no register/memory write.
  - Stays halted until reset; inst_out keeps showing 0x0000000C.
  - A bench sampling at any later posedge still sees the syscall.
- Reset mid-program: immediately forces PC/registers to reset values irrespective of clk; execution restarts from RESET_PC after release.

Decomposition:
- Package mips_pkg: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI…OP_LUI, OP_LW, OP_SW), funct constants (F_ADD…F_JR, F_SYSCALL=6'h0C), ALU-op enum, SYSCALL_WORD=32'h0000000C.
- Sub-modules: mips_regfile (32x32, 2R1W, $0 hardwired) is the natural one. mips_alu may optionally be split out. Control decode and memories stay in the top.

Test Plan:
- Reset: hold rst 20 ns, then release -> PC=0, v0=0 during reset; PC=4 after first posedge following release.
- Arithmetic then halt:
  - Program: addi $2,$0,5; addi $3,$0,7; add $2,$2,$3; syscall.
  - Required: syscall observed on inst at PC=0x0C, v0=12, PC stays 0x0C on subsequent edges.
- Memory:
  - Program: addi $8,$0,0x55; sw $8,16($0); lw $2,16($0); syscall.
  - Required: v0=0x55 at halt.
- Branch and jump:
  - Program: beq $0,$0,+1 skips an addi $2,$0,1; then addi $2,$0,9; j to syscall.
  - Required: v0=9, skipped instruction has no effect.
- Loop plus $0 guard:
  - Program: sum 1..10 into $2 using bne loop; addi $0,$0,3 inside the loop.
  - Required: v0=55 at syscall, $0 still 0, halt well before 5000 ns.
- Async reset mid-run: assert rst between clock edges during the loop -> PC and v0 go to 0 immediately; rerun yields v0=55 again.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings and the ALU datapath function for the single-cycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR} pc_sel_e;

  // Shifts act on the b operand (rt); lui takes its half-word from b.
  function automatic logic [31:0] alu_compute(input alu_op_e op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] y;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {31'd0, (a < b)};
      ALU_SLL:  y = b << sh;
      ALU_SRL:  y = b >> sh;
      ALU_SRA:  y = $unsigned($signed(b) >>> sh);
      ALU_LUI:  y = {b[15:0], 16'h0000};
      default:  y = 32'h0000_0000;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, $0 fixed at zero.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] v0
);

  logic [31:0] regs_r [32];

  // Register storage; writes to $0 are dropped so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (we && (wa != 5'd0)) begin
      regs_r[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd1 = (ra1 == 5'd0) ? 32'h0000_0000 : regs_r[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0000_0000 : regs_r[ra2];
  assign v0  = regs_r[2];

endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS core: ROM fetch, decode, ALU, data RAM and next-PC all resolve within one clock.
module mips_core
  import mips_pkg::*;
#(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter string       IMEM_FILE  = "program.hex",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  output logic [31:0] inst_out,
  output logic [31:0] v0
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] pc_r;
  logic [31:0] inst;
  logic [31:0] pc4_s;
  logic [31:0] next_pc_s;
  logic [31:0] rs_val_s;
  logic [31:0] rt_val_s;
  logic [31:0] imm_s;
  logic [31:0] alu_b_s;
  logic [31:0] alu_y_s;
  logic [31:0] mem_rd_s;
  logic [31:0] wd_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;
  logic        halt_s;

  alu_op_e     alu_op_s;
  wb_sel_e     wb_sel_s;
  pc_sel_e     pc_sel_s;
  logic        use_imm_s;
  logic        zext_s;
  logic        reg_we_s;
  logic        mem_we_s;
  logic [4:0]  wa_s;

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  shamt_s;
  logic [15:0] imm16_s;

  assign inst     = imem[pc_r[IA_W+1:2]];
  assign inst_out = inst;
  assign PC       = pc_r;

  assign op_s    = inst[31:26];
  assign rs_s    = inst[25:21];
  assign rt_s    = inst[20:16];
  assign rd_s    = inst[15:11];
  assign shamt_s = inst[10:6];
  assign funct_s = inst[5:0];
  assign imm16_s = inst[15:0];

  // syscall freezes the PC and suppresses every write until the next reset.
  assign halt_s = (inst == SYSCALL_WORD);

  mips_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .we  (reg_we_s && !halt_s),
    .ra1 (rs_s),
    .ra2 (rt_s),
    .wa  (wa_s),
    .wd  (wd_s),
    .rd1 (rs_val_s),
    .rd2 (rt_val_s),
    .v0  (v0)
  );

  // Instruction decode into datapath controls; unknown encodings fall through as NOPs.
  always_comb begin
    alu_op_s  = ALU_ADD;
    wb_sel_s  = WB_ALU;
    pc_sel_s  = PC_SEQ;
    use_imm_s = 1'b0;
    zext_s    = 1'b0;
    reg_we_s  = 1'b0;
    mem_we_s  = 1'b0;
    wa_s      = rd_s;
    case (op_s)
      OP_RTYPE: begin
        reg_we_s = 1'b1;
        case (funct_s)
          F_ADD, F_ADDU: alu_op_s = ALU_ADD;
          F_SUB, F_SUBU: alu_op_s = ALU_SUB;
          F_AND:         alu_op_s = ALU_AND;
          F_OR:          alu_op_s = ALU_OR;
          F_XOR:         alu_op_s = ALU_XOR;
          F_NOR:         alu_op_s = ALU_NOR;
          F_SLT:         alu_op_s = ALU_SLT;
          F_SLTU:        alu_op_s = ALU_SLTU;
          F_SLL:         alu_op_s = ALU_SLL;
          F_SRL:         alu_op_s = ALU_SRL;
          F_SRA:         alu_op_s = ALU_SRA;
          F_JR: begin
            reg_we_s = 1'b0;
            pc_sel_s = PC_JR;
          end
          default:       reg_we_s = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        use_imm_s = 1'b1;
        reg_we_s  = 1'b1;
        wa_s      = rt_s;
      end
      OP_SLTI: begin
        alu_op_s  = ALU_SLT;
        use_imm_s = 1'b1;
        reg_we_s  = 1'b1;
        wa_s      = rt_s;
      end
      OP_SLTIU: begin
        alu_op_s  = ALU_SLTU;
        use_imm_s = 1'b1;
        reg_we_s  = 1'b1;
        wa_s      = rt_s;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        alu_op_s  = (op_s == OP_ANDI) ? ALU_AND :
                    (op_s == OP_ORI)  ? ALU_OR  :
                    (op_s == OP_XORI) ? ALU_XOR : ALU_LUI;
        use_imm_s = 1'b1;
        zext_s    = 1'b1;
        reg_we_s  = 1'b1;
        wa_s      = rt_s;
      end
      OP_LW: begin
        use_imm_s = 1'b1;
        reg_we_s  = 1'b1;
        wb_sel_s  = WB_MEM;
        wa_s      = rt_s;
      end
      OP_SW: begin
        use_imm_s = 1'b1;
        mem_we_s  = 1'b1;
      end
      OP_BEQ:  pc_sel_s = (rs_val_s == rt_val_s) ? PC_BRANCH : PC_SEQ;
      OP_BNE:  pc_sel_s = (rs_val_s != rt_val_s) ? PC_BRANCH : PC_SEQ;
      OP_J:    pc_sel_s = PC_JUMP;
      OP_JAL: begin
        pc_sel_s = PC_JUMP;
        reg_we_s = 1'b1;
        wb_sel_s = WB_PC4;
        wa_s     = 5'd31;
      end
      default: reg_we_s = 1'b0;
    endcase
  end

  assign imm_s    = zext_s ? {16'h0000, imm16_s} : {{16{imm16_s[15]}}, imm16_s};
  assign alu_b_s  = use_imm_s ? imm_s : rt_val_s;
  assign alu_y_s  = alu_compute(alu_op_s, rs_val_s, alu_b_s, shamt_s);
  assign mem_rd_s = dmem[alu_y_s[DA_W+1:2]];

  assign pc4_s       = pc_r + 32'd4;
  assign br_target_s = pc4_s + {{14{imm16_s[15]}}, imm16_s, 2'b00};
  assign j_target_s  = {pc4_s[31:28], inst[25:0], 2'b00};

  // Register write-back source select.
  always_comb begin
    wd_s = alu_y_s;
    case (wb_sel_s)
      WB_ALU:  wd_s = alu_y_s;
      WB_MEM:  wd_s = mem_rd_s;
      WB_PC4:  wd_s = pc4_s;
      default: wd_s = alu_y_s;
    endcase
  end

  // Next-PC select; a halted core re-presents the same PC forever.
  always_comb begin
    next_pc_s = pc4_s;
    if (halt_s) begin
      next_pc_s = pc_r;
    end else begin
      case (pc_sel_s)
        PC_SEQ:    next_pc_s = pc4_s;
        PC_BRANCH: next_pc_s = br_target_s;
        PC_JUMP:   next_pc_s = j_target_s;
        PC_JR:     next_pc_s = rs_val_s;
        default:   next_pc_s = pc4_s;
      endcase
    end
  end

  // Program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Data RAM write port; contents survive reset, but no store lands while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we_s && !halt_s && !rst) begin
      dmem[alu_y_s[DA_W+1:2]] <= rt_val_s;
    end
  end

endmodule

// File: tb/tb_mips_core.sv
// Directed program tests for mips_core: programs are poked into the instruction ROM and results read from PC/v0.
module tb_mips_core;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] inst_out;
  logic [31:0] v0;

  int n_checks;
  int n_errors;

  logic [31:0] prog [64];

  mips_core #(.IMEM_FILE("")) dut (
    .clk      (clk),
    .rst      (rst),
    .PC       (pc),
    .inst_out (inst_out),
    .v0       (v0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%08h expected=%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0000;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.imem[i] = (i < 64) ? prog[i] : 32'h0000_0000;
  endtask

  task automatic start_prog();
    @(negedge clk);
    rst = 1'b1;
    load_prog();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int budget, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (dut.inst == 32'h0000_000C) seen = 1'b1;
    end
    check_val({tag, "_halted"}, {31'd0, seen}, 32'd1);
  endtask

  logic [31:0] exp_pc [21];
  logic [31:0] exp_v0 [21];

  initial begin
    int cyc;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;

    // Arithmetic then halt, with the reset window checks.
    clear_prog();
    prog[0] = i_op(6'h08, 5'd0, 5'd2, 16'd5);
    prog[1] = i_op(6'h08, 5'd0, 5'd3, 16'd7);
    prog[2] = r_op(5'd2, 5'd3, 5'd2, 5'd0, 6'h20);
    prog[3] = 32'h0000_000C;
    load_prog();
    #12;
    check_val("rst_pc", pc, 32'h0000_0000);
    check_val("rst_v0", v0, 32'h0000_0000);
    check_val("rst_inst", inst_out, 32'h2002_0005);
    #8;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("first_pc", pc, 32'h0000_0004);
    run_to_halt("arith", 20, cyc);
    check_val("arith_pc", pc, 32'h0000_000C);
    check_val("arith_v0", v0, 32'd12);
    repeat (3) @(posedge clk);
    #1;
    check_val("arith_hold_pc", pc, 32'h0000_000C);
    check_val("arith_hold_inst", inst_out, 32'h0000_000C);
    check_val("arith_hold_v0", v0, 32'd12);

    // Store then load back through data RAM.
    clear_prog();
    prog[0] = i_op(6'h08, 5'd0, 5'd8, 16'h0055);
    prog[1] = i_op(6'h2B, 5'd0, 5'd8, 16'd16);
    prog[2] = i_op(6'h23, 5'd0, 5'd2, 16'd16);
    prog[3] = 32'h0000_000C;
    start_prog();
    run_to_halt("mem", 20, cyc);
    check_val("mem_v0", v0, 32'h0000_0055);

    // Taken beq skips one instruction, j skips another.
    clear_prog();
    prog[0] = i_op(6'h04, 5'd0, 5'd0, 16'd1);
    prog[1] = i_op(6'h08, 5'd0, 5'd2, 16'd1);
    prog[2] = i_op(6'h08, 5'd0, 5'd2, 16'd9);
    prog[3] = j_op(6'h02, 26'h000_0005);
    prog[4] = i_op(6'h08, 5'd0, 5'd2, 16'd2);
    prog[5] = 32'h0000_000C;
    start_prog();
    run_to_halt("branch", 20, cyc);
    check_val("branch_v0", v0, 32'd9);
    check_val("branch_pc", pc, 32'h0000_0014);

    // ALU/immediate/jal/jr walk, checked after every instruction.
    clear_prog();
    prog[0]  = i_op(6'h08, 5'd0, 5'd3, 16'hFFF8);
    prog[1]  = i_op(6'h0F, 5'd0, 5'd2, 16'h1234);
    prog[2]  = i_op(6'h0D, 5'd2, 5'd2, 16'h8001);
    prog[3]  = r_op(5'd0, 5'd3, 5'd2, 5'd1, 6'h03);
    prog[4]  = r_op(5'd0, 5'd3, 5'd2, 5'd28, 6'h02);
    prog[5]  = r_op(5'd0, 5'd3, 5'd2, 5'd4, 6'h00);
    prog[6]  = r_op(5'd3, 5'd0, 5'd2, 5'd0, 6'h2A);
    prog[7]  = r_op(5'd3, 5'd0, 5'd2, 5'd0, 6'h2B);
    prog[8]  = i_op(6'h0A, 5'd3, 5'd2, 16'hFFF9);
    prog[9]  = i_op(6'h0B, 5'd3, 5'd2, 16'd5);
    prog[10] = r_op(5'd0, 5'd3, 5'd2, 5'd0, 6'h22);
    prog[11] = i_op(6'h0C, 5'd3, 5'd2, 16'hFF0F);
    prog[12] = i_op(6'h0E, 5'd3, 5'd2, 16'h00FF);
    prog[13] = r_op(5'd3, 5'd0, 5'd2, 5'd0, 6'h27);
    prog[14] = r_op(5'd2, 5'd3, 5'd2, 5'd0, 6'h26);
    prog[15] = r_op(5'd2, 5'd3, 5'd2, 5'd0, 6'h24);
    prog[16] = r_op(5'd3, 5'd3, 5'd2, 5'd0, 6'h21);
    prog[17] = j_op(6'h03, 26'h000_0014);
    prog[18] = 32'h0000_000C;
    prog[19] = i_op(6'h08, 5'd0, 5'd2, 16'd1);
    prog[20] = r_op(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
    prog[21] = r_op(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    exp_pc = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24,
               32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h50,
               32'h54, 32'h48, 32'h48};
    exp_v0 = '{32'h0000_0000, 32'h1234_0000, 32'h1234_8001, 32'hFFFF_FFFC, 32'h0000_000F,
               32'hFFFF_FF80, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000,
               32'h0000_0008, 32'h0000_FF08, 32'hFFFF_FF07, 32'h0000_0007, 32'hFFFF_FFFF,
               32'hFFFF_FFF8, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0000_0048, 32'h0000_0048,
               32'h0000_0048};
    start_prog();
    for (int k = 0; k < 21; k++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("alu%0d_pc", k), pc, exp_pc[k]);
      check_val($sformatf("alu%0d_v0", k), v0, exp_v0[k]);
    end

    // Sum 1..10 with bne, writing $0 inside the loop and folding $0 into the result.
    clear_prog();
    prog[0] = i_op(6'h08, 5'd0, 5'd2, 16'd0);
    prog[1] = i_op(6'h08, 5'd0, 5'd3, 16'd1);
    prog[2] = i_op(6'h08, 5'd0, 5'd4, 16'd11);
    prog[3] = r_op(5'd2, 5'd3, 5'd2, 5'd0, 6'h20);
    prog[4] = i_op(6'h08, 5'd3, 5'd3, 16'd1);
    prog[5] = i_op(6'h08, 5'd0, 5'd0, 16'd3);
    prog[6] = i_op(6'h05, 5'd3, 5'd4, 16'hFFFC);
    prog[7] = r_op(5'd2, 5'd0, 5'd2, 5'd0, 6'h20);
    prog[8] = 32'h0000_000C;
    start_prog();
    run_to_halt("loop", 400, cyc);
    check_val("loop_v0", v0, 32'd55);
    check_val("loop_pc", pc, 32'h0000_0020);
    check_val("loop_cycles", cyc, 32'd44);

    // Async reset in the middle of the loop, then rerun.
    start_prog();
    repeat (15) @(posedge clk);
    #1;
    check_val("mid_v0", v0, 32'd6);
    check_val("mid_pc", pc, 32'h0000_000C);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_pc", pc, 32'h0000_0000);
    check_val("async_rst_v0", v0, 32'h0000_0000);
    @(posedge clk);
    #1;
    check_val("rst_hold_pc", pc, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    run_to_halt("rerun", 400, cyc);
    check_val("rerun_v0", v0, 32'd55);
    check_val("rerun_cycles", cyc, 32'd44);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
